// File: rtl/d0_scheduler.sv
// d0_scheduler: stage-d0 source arbiter for the L1 data cache.
// Chooses RstBlock / D1 / L2Cache / UpdateL2 / LSQ each cycle and owns the
// reset-sweep and update-sweep set counters. Outputs are combinational.
// Optional build macro D0_SCHED_STARVE_EN: LSQ anti-starvation promotion.

package d0_sched_pkg;
  typedef enum logic [2:0] {
    WIN_RST_BLOCK = 3'd0,
    WIN_D1        = 3'd1,
    WIN_L2CACHE   = 3'd2,
    WIN_UPDATE_L2 = 3'd3,
    WIN_LSQ       = 3'd4
  } d0_winner_e;
endpackage

module d0_scheduler
  import d0_sched_pkg::*;
#(
  parameter int N_SETS = 64
`ifdef D0_SCHED_STARVE_EN
  , parameter int STARVE_MAX = 8
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      d0_ready_i,
  input  logic                      d1_valid_i,
  output logic                      d1_ready_o,
  input  logic                      l2c_valid_i,
  output logic                      l2c_ready_o,
  input  logic                      lsq_valid_i,
  output logic                      lsq_ready_o,
  input  logic                      upd_start_i,
  output logic                      upd_busy_o,
  output logic                      upd_done_o,
  output logic [$clog2(N_SETS)-1:0] upd_idx_o,
  output logic                      rst_busy_o,
  output logic [$clog2(N_SETS)-1:0] rst_idx_o,
  output d0_winner_e                winner_o,
  output logic                      winner_valid_o
);

  localparam int IDX_W = $clog2(N_SETS);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  typedef enum logic {S_RST, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rst_cnt_q, upd_cnt_q;
  logic              upd_pend_q, upd_busy_q;
  logic              promote;
  d0_winner_e        arb_win;
  logic              arb_any;
  logic              rst_acc, run_acc, upd_acc;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_RST;
    else         state_q <= state_d;
  end

  // Next state: leave the reset sweep once the last set is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   if (d0_ready_i && rst_cnt_q == LAST_SET) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // RUN-mode arbitration; a starving LSQ jumps above L2Cache and UpdateL2
  always_comb begin
    arb_win = WIN_LSQ;
    arb_any = 1'b1;
    if (d1_valid_i)                  arb_win = WIN_D1;
    else if (promote && lsq_valid_i) arb_win = WIN_LSQ;
    else if (l2c_valid_i)            arb_win = WIN_L2CACHE;
    else if (upd_busy_q)             arb_win = WIN_UPDATE_L2;
    else if (lsq_valid_i)            arb_win = WIN_LSQ;
    else                             arb_any = 1'b0;
  end

  assign rst_acc = (state_q == S_RST) && d0_ready_i;
  assign run_acc = (state_q == S_RUN) && arb_any && d0_ready_i;
  assign upd_acc = run_acc && (arb_win == WIN_UPDATE_L2);

  // Outputs: RST drives the invalidation sweep, RUN the arbitration result
  always_comb begin
    winner_o       = arb_win;
    winner_valid_o = 1'b0;
    d1_ready_o     = 1'b0;
    l2c_ready_o    = 1'b0;
    lsq_ready_o    = 1'b0;
    upd_done_o     = 1'b0;
    rst_busy_o     = 1'b0;
    rst_idx_o      = rst_cnt_q;
    upd_busy_o     = upd_busy_q;
    upd_idx_o      = upd_cnt_q;
    case (state_q)
      S_RST: begin
        winner_o       = WIN_RST_BLOCK;
        winner_valid_o = d0_ready_i;
        rst_busy_o     = 1'b1;
      end
      default: begin
        winner_valid_o = run_acc;
        d1_ready_o     = run_acc && (arb_win == WIN_D1);
        l2c_ready_o    = run_acc && (arb_win == WIN_L2CACHE);
        lsq_ready_o    = run_acc && (arb_win == WIN_LSQ);
        upd_done_o     = upd_acc && (upd_cnt_q == LAST_SET);
      end
    endcase
  end

  // Reset-sweep set counter, advances on each RstBlock accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rst_cnt_q <= '0;
    else if (rst_acc) rst_cnt_q <= (rst_cnt_q == LAST_SET) ? '0 : rst_cnt_q + 1'b1;
  end

  // Update sweep: a start seen during RST is held until the first RUN cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_pend_q <= 1'b0;
      upd_busy_q <= 1'b0;
      upd_cnt_q  <= '0;
    end else if (state_q == S_RST) begin
      if (rst_acc && rst_cnt_q == LAST_SET) begin
        upd_busy_q <= upd_pend_q | upd_start_i;
        upd_pend_q <= 1'b0;
      end else begin
        upd_pend_q <= upd_pend_q | upd_start_i;
      end
    end else if (!upd_busy_q && upd_start_i) begin
      upd_busy_q <= 1'b1;
    end else if (upd_acc) begin
      if (upd_cnt_q == LAST_SET) begin
        upd_cnt_q  <= '0;
        upd_busy_q <= 1'b0;
      end else begin
        upd_cnt_q  <= upd_cnt_q + 1'b1;
      end
    end
  end

`ifdef D0_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt_q;

  // Count LSQ denials while it waits with d0 ready; saturate at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      if (!lsq_valid_i || lsq_ready_o)
        starve_cnt_q <= '0;
      else if (d0_ready_i && starve_cnt_q != SW'(STARVE_MAX))
        starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  assign promote = (starve_cnt_q == SW'(STARVE_MAX));
`else
  assign promote = 1'b0;
`endif

endmodule

// File: tb/tb_d0_scheduler.sv
// Bench for d0_scheduler: a cycle-level reference model computes the expected
// outputs per cycle into a queue; a monitor pops and compares them.
module tb_d0_scheduler;
  import d0_sched_pkg::*;

  localparam int N    = 64;
  localparam int SMAX = 8;
`ifdef D0_SCHED_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       d1r, l2r, lqr, ub, ud;
    logic [5:0] ui;
    logic       rb;
    logic [5:0] ri;
    logic [2:0] w;
    logic       wv;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, d0r = 1'b0, d1v = 1'b0, l2v = 1'b0, lqv = 1'b0, us = 1'b0;
  logic d1_ready, l2c_ready, lsq_ready, upd_busy, upd_done, rst_busy, winner_valid;
  logic [5:0] upd_idx, rst_idx;
  d0_winner_e winner;

  int checks = 0;
  int errors = 0;
  obs_t expq[$];

  // model state
  bit m_in_rst;
  int m_rset, m_uset, m_starve;
  bit m_busy, m_pend;

  always #5 clk = ~clk;

  d0_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .d0_ready_i(d0r),
    .d1_valid_i(d1v), .d1_ready_o(d1_ready),
    .l2c_valid_i(l2v), .l2c_ready_o(l2c_ready),
    .lsq_valid_i(lqv), .lsq_ready_o(lsq_ready),
    .upd_start_i(us), .upd_busy_o(upd_busy), .upd_done_o(upd_done), .upd_idx_o(upd_idx),
    .rst_busy_o(rst_busy), .rst_idx_o(rst_idx),
    .winner_o(winner), .winner_valid_o(winner_valid)
  );

  // One cycle of stimulus: drive, predict, then step the model across the edge
  task automatic cyc(input bit r, input bit d, input bit a, input bit b, input bit c, input bit s);
    obs_t e;
    d0_winner_e ord[4];
    d0_winner_e w;
    bit got, acc, req;
    @(negedge clk);
    rst_n = r; d0r = d; d1v = a; l2v = b; lqv = c; us = s;
    if (!r) begin
      m_in_rst = 1; m_rset = 0; m_uset = 0; m_busy = 0; m_pend = 0; m_starve = 0;
    end
    e = '0;
    e.ub = m_busy;
    e.ui = 6'(m_uset);
    e.ri = 6'(m_rset);
    w = WIN_LSQ; got = 0; acc = 0;
    if (m_in_rst) begin
      e.w = 3'(WIN_RST_BLOCK); e.wv = d; e.rb = 1;
    end else begin
      if (STARVE_EN && m_starve >= SMAX) ord = '{WIN_D1, WIN_LSQ, WIN_L2CACHE, WIN_UPDATE_L2};
      else                               ord = '{WIN_D1, WIN_L2CACHE, WIN_UPDATE_L2, WIN_LSQ};
      foreach (ord[i]) begin
        case (ord[i])
          WIN_D1:        req = a;
          WIN_L2CACHE:   req = b;
          WIN_UPDATE_L2: req = m_busy;
          default:       req = c;
        endcase
        if (req && !got) begin w = ord[i]; got = 1; end
      end
      acc = got && d;
      e.w = 3'(w); e.wv = acc;
      e.d1r = acc && w == WIN_D1;
      e.l2r = acc && w == WIN_L2CACHE;
      e.lqr = acc && w == WIN_LSQ;
      e.ud  = acc && w == WIN_UPDATE_L2 && m_uset == N - 1;
    end
    expq.push_back(e);
    if (r) begin
      if (m_in_rst) begin
        if (d && m_rset == N - 1) begin
          m_in_rst = 0; m_rset = 0; m_busy = m_pend | s; m_pend = 0;
        end else begin
          m_pend = m_pend | s;
          if (d) m_rset++;
        end
      end else begin
        if (!m_busy && s) m_busy = 1;
        else if (acc && w == WIN_UPDATE_L2) begin
          if (m_uset == N - 1) begin m_uset = 0; m_busy = 0; end
          else m_uset++;
        end
        if (!c || (acc && w == WIN_LSQ)) m_starve = 0;
        else if (d && m_starve < SMAX) m_starve++;
      end
    end
  endtask

  // Monitor: compare what the DUT presents this cycle against the next prediction
  always @(negedge clk) begin
    obs_t act, ex;
    #2;
    if (expq.size() > 0) begin
      ex = expq.pop_front();
      act = '{d1_ready, l2c_ready, lsq_ready, upd_busy, upd_done, upd_idx,
              rst_busy, rst_idx, 3'(winner), winner_valid};
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got w=%0d wv=%0b rdy(d1,l2,lsq)=%0b%0b%0b ub=%0b ud=%0b ui=%0d rb=%0b ri=%0d expected w=%0d wv=%0b rdy=%0b%0b%0b ub=%0b ud=%0b ui=%0d rb=%0b ri=%0d",
                 $time, act.w, act.wv, act.d1r, act.l2r, act.lqr, act.ub, act.ud, act.ui, act.rb, act.ri,
                 ex.w, ex.wv, ex.d1r, ex.l2r, ex.lqr, ex.ub, ex.ud, ex.ui, ex.rb, ex.ri);
      end
    end
  end

  initial begin
    // reset values
    repeat (3) cyc(0, 1, 1, 1, 1, 0);
    // reset sweep with noisy requesters
    repeat (70) cyc(1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    // priority ladder
    cyc(1, 1, 1, 1, 1, 0);
    cyc(1, 1, 0, 1, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 0);
    // full update sweep against a waiting LSQ
    cyc(1, 1, 0, 0, 1, 1);
    repeat (70) cyc(1, 1, 0, 0, 1, 0);
    // stall mid-sweep at set 10
    cyc(1, 1, 0, 0, 0, 1);
    repeat (10) cyc(1, 1, 0, 0, 0, 0);
    repeat (5)  cyc(1, 0, 0, 0, 1, 1);
    repeat (60) cyc(1, 1, 0, 0, 0, 0);
    // start latched during RST, then reset pulse mid-sweep
    repeat (2) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    repeat (63) cyc(1, 1, 0, 0, 0, 0);
    repeat (21) cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (70) cyc(1, 1, 0, 0, 0, 0);
    // L2 and LSQ both pending continuously
    repeat (30) cyc(1, 1, 0, 1, 1, 0);
    // random traffic
    repeat (600) cyc(($urandom_range(0, 249) != 0), ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 19) == 0));
    cyc(1, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
